// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} kp_state_t;

  // Width of a key code able to number every key, never narrower than one bit.
  function automatic int code_width(input int nkeys);
    return (nkeys > 2) ? $clog2(nkeys) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser; resets to all-ones so idle (pulled-up) rows read as released.
module sync_2ff #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Column-scanning 4x4 keypad reader with debounced press/release and a one-entry
// key buffer using a valid/ack handshake.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter  int NROWS          = 4,
  parameter  int NCOLS          = 4,
  parameter  int SCAN_DIV       = 50000,
  parameter  int DEBOUNCE_SCANS = 20,
  localparam int CW             = code_width(NROWS * NCOLS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NROWS-1:0] row_i,
  output logic [NCOLS-1:0] col_o,
  output logic [CW-1:0]    key_code_o,
  output logic             key_valid_o,
  input  logic             key_ack_i,
  output logic             key_down_o,
  output logic             overrun_o
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam int COL_W = (NCOLS > 2) ? $clog2(NCOLS) : 1;
  localparam int ROW_W = (NROWS > 2) ? $clog2(NROWS) : 1;

  logic [NROWS-1:0] row_s;
  logic [DIV_W-1:0] div;
  logic             tick;
  kp_state_t        state;
  logic [COL_W-1:0] col_idx;
  logic [COL_W-1:0] next_col;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [ROW_W-1:0] cap_row;
  logic [ROW_W-1:0] win;
  logic             any_low;
  logic             same_row;
  logic             press_evt;
  logic [CW-1:0]    new_code;

  sync_2ff #(.W(NROWS)) u_row_sync (
    .clk (clk),
    .rst (rst),
    .d   (row_i),
    .q   (row_s)
  );

  assign tick = (div == DIV_W'(SCAN_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || tick) begin
      div <= '0;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  // Lowest-numbered low row wins when several keys in the column are pressed.
  always_comb begin
    any_low = 1'b0;
    win     = '0;
    for (int r = NROWS - 1; r >= 0; r--) begin
      if (!row_s[r]) begin
        any_low = 1'b1;
        win     = ROW_W'(r);
      end
    end
  end

  always_comb begin
    col_o          = '1;
    col_o[col_idx] = 1'b0;
  end

  assign next_col  = (col_idx == COL_W'(NCOLS - 1)) ? '0 : col_idx + COL_W'(1);
  assign cnt_next  = cnt + CNT_W'(1);
  assign same_row  = any_low && (win == cap_row);
  assign press_evt = tick && (state == DEBOUNCE) && same_row
                     && (cnt_next == CNT_W'(DEBOUNCE_SCANS));
  assign new_code  = CW'(int'(col_idx) * NROWS + int'(cap_row));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SCAN;
      col_idx    <= '0;
      cnt        <= '0;
      cap_row    <= '0;
      key_down_o <= 1'b0;
    end else if (tick) begin
      unique case (state)
        SCAN: begin
          if (any_low) begin
            cap_row <= win;
            cnt     <= CNT_W'(1);
            state   <= DEBOUNCE;
          end else begin
            col_idx <= next_col;
          end
        end
        DEBOUNCE: begin
          if (same_row) begin
            if (cnt_next == CNT_W'(DEBOUNCE_SCANS)) begin
              state      <= HELD;
              cnt        <= '0;
              key_down_o <= 1'b1;
            end else begin
              cnt <= cnt_next;
            end
          end else begin
            state   <= SCAN;
            col_idx <= next_col;
          end
        end
        HELD: begin
          // Any low sample on the held row restarts the release count.
          if (row_s[cap_row]) begin
            if (cnt_next == CNT_W'(DEBOUNCE_SCANS)) begin
              state      <= SCAN;
              cnt        <= '0;
              key_down_o <= 1'b0;
              col_idx    <= next_col;
            end else begin
              cnt <= cnt_next;
            end
          end else begin
            cnt <= '0;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_code_o  <= '0;
      key_valid_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else if (press_evt) begin
      if (!key_valid_o || key_ack_i) begin
        key_code_o  <= new_code;
        key_valid_o <= 1'b1;
      end else begin
        overrun_o <= 1'b1;
      end
    end else if (key_ack_i && key_valid_o) begin
      key_valid_o <= 1'b0;
      overrun_o   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomised bench: a physical keypad matrix drives the rows from col_o, and a
// tick-level reference model predicts every output each cycle.
module tb_keypad_scanner;

  localparam int NROWS    = 4;
  localparam int NCOLS    = 4;
  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
  localparam int NCYC     = 6000;

  logic             clk = 1'b0;
  logic             rst;
  logic [NROWS-1:0] row_i;
  logic [NCOLS-1:0] col_o;
  logic [3:0]       key_code_o;
  logic             key_valid_o;
  logic             key_ack_i;
  logic             key_down_o;
  logic             overrun_o;

  // mat[c][r] = 1 means the key at column c, row r is physically pressed.
  logic [NCOLS-1:0][NROWS-1:0] mat;

  int compared   = 0;
  int mismatched = 0;

  int n, mcol, track, cap;
  int conf_q[$];
  bit rel_q[$];
  bit m_valid, m_down, m_over;
  int m_code;
  int ack_rate;
  bit forced_done;

  always #5 clk = ~clk;

  always_comb begin
    row_i = '1;
    for (int c = 0; c < NCOLS; c++)
      for (int r = 0; r < NROWS; r++)
        if (!col_o[c] && mat[c][r]) row_i[r] = 1'b0;
  end

  keypad_scanner #(
    .NROWS          (NROWS),
    .NCOLS          (NCOLS),
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .row_i       (row_i),
    .col_o       (col_o),
    .key_code_o  (key_code_o),
    .key_valid_o (key_valid_o),
    .key_ack_i   (key_ack_i),
    .key_down_o  (key_down_o),
    .overrun_o   (overrun_o)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int winner(input int c);
    for (int r = 0; r < NROWS; r++)
      if (mat[c][r]) return r;
    return -1;
  endfunction

  task automatic modelReset();
    n = 0; mcol = 0; track = 0; cap = 0;
    conf_q.delete(); rel_q.delete();
    m_valid = 0; m_down = 0; m_over = 0; m_code = 0;
  endtask

  // One clock edge of the reference: scanning rules apply only on scan ticks,
  // the key buffer reacts to press events and acks on every edge.
  task automatic modelStep(input bit a);
    bit ev;
    int w;
    ev = 0;
    if (n % SCAN_DIV == SCAN_DIV - 1) begin
      w = winner(mcol);
      if (track == 0) begin
        if (w >= 0) begin
          cap = w; conf_q = {w}; track = 1;
        end else begin
          mcol = (mcol + 1) % NCOLS;
        end
      end else if (track == 1) begin
        if (w == cap) begin
          conf_q.push_back(w);
          if (conf_q.size() == DEB) begin
            ev = 1; track = 2; m_down = 1; rel_q.delete();
          end
        end else begin
          track = 0; mcol = (mcol + 1) % NCOLS;
        end
      end else begin
        if (mat[mcol][cap]) rel_q.delete();
        else rel_q.push_back(1'b1);
        if (rel_q.size() == DEB) begin
          track = 0; m_down = 0; mcol = (mcol + 1) % NCOLS;
        end
      end
    end
    n++;
    if (ev) begin
      if (!m_valid || a) begin
        m_code = mcol * NROWS + cap; m_valid = 1;
      end else begin
        m_over = 1;
      end
    end else if (a && m_valid) begin
      m_valid = 0; m_over = 0;
    end
  endtask

  task automatic newMatrix();
    int k;
    k = $urandom_range(0, 9);
    mat = '0;
    if (k >= 4) mat[$urandom_range(0, NCOLS - 1)][$urandom_range(0, NROWS - 1)] = 1'b1;
    if (k >= 8) begin
      if (k == 8) mat[$urandom_range(0, NCOLS - 1)][$urandom_range(0, NROWS - 1)] = 1'b1;
      else        mat[mcol][$urandom_range(0, NROWS - 1)] = 1'b1;
    end
  endtask

  // Matrix changes only just after a tick so the synchroniser settles before the next one.
  task automatic applyStimulus(input int cyc);
    bit do_rst;
    bit a;
    if (cyc % 250 == 0) begin
      case ($urandom_range(0, 2))
        0:       ack_rate = 0;
        1:       ack_rate = 40;
        default: ack_rate = 4;
      endcase
    end
    do_rst = ($urandom_range(0, 399) == 0);
    if (!forced_done && track == 1 && cyc > 1500) begin
      do_rst = 1; forced_done = 1;
    end
    a = (ack_rate != 0) && ($urandom_range(1, ack_rate) == 1);
    key_ack_i = a;
    if (do_rst) begin
      rst = 1'b1;
      modelReset();
    end else begin
      rst = 1'b0;
      if (n % SCAN_DIV == 0 && $urandom_range(0, 5) == 0) newMatrix();
      modelStep(a);
    end
  endtask

  task automatic checkAll();
    logic [NCOLS-1:0] ecol;
    ecol       = '1;
    ecol[mcol] = 1'b0;
    checkOutput("col_o", col_o, ecol);
    checkOutput("key_valid_o", key_valid_o, m_valid);
    checkOutput("key_down_o", key_down_o, m_down);
    checkOutput("overrun_o", overrun_o, m_over);
    checkOutput("key_code_o", key_code_o, m_code);
  endtask

  initial begin
    mat         = '0;
    key_ack_i   = 1'b0;
    rst         = 1'b1;
    ack_rate    = 4;
    forced_done = 0;
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkAll();
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      applyStimulus(cyc);
      @(posedge clk);
      @(negedge clk);
      checkAll();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
